// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare predictor and its in-flight queue.
package bp_pkg;

    // Widest table index the in-flight entry can carry; instances use the low INDEX_W bits.
    localparam int IDX_MAX_W = 16;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } bp_state_e;

    typedef struct packed {
        logic [IDX_MAX_W-1:0] idx;
        logic                 pred;
    } bp_entry_t;

    // Weakly-not-taken value for a counter of ctr_w bits: 0111.. pattern of width ctr_w.
    function automatic int weak_nt(input int ctr_w);
        return (1 << (ctr_w - 1)) - 1;
    endfunction

    // One saturating step of a ctr_w-bit counter toward taken or not-taken.
    function automatic int sat_step(input int ctr, input logic taken, input int ctr_w);
        int ctr_max;
        ctr_max = (1 << ctr_w) - 1;
        if (taken) begin
            return (ctr >= ctr_max) ? ctr_max : ctr + 1;
        end
        return (ctr <= 0) ? 0 : ctr - 1;
    endfunction

endpackage

// File: rtl/bp_inflight_q.sv
// In-order circular queue of unresolved predictions. Count is held separately from
// the pointers so full and empty never alias; clear empties the queue in one cycle.
module bp_inflight_q
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clear,
    input  logic                    push,
    input  bp_entry_t               push_data,
    input  logic                    pop,
    output bp_entry_t               head,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    bp_entry_t          mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   cnt;
    logic               do_push;
    logic               do_pop;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push & ~full & ~clear;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    // Pointers wrap naturally because DEPTH is a power of two; clear wins over push/pop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage needs no reset: only slots between rd_ptr and wr_ptr are ever read as valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/gshare_predictor_q.sv
// Gshare direction predictor: counter table indexed by pc ^ speculative history,
// in-order queue of in-flight predictions, history repair on mispredict or flush,
// and a post-reset sweep of the table to weakly-not-taken.
//
// Handshake: a lookup transfers on a cycle where pred_req && pred_ready; pred_ready
// depends only on state and queue fullness, never on the resolve inputs. A resolve
// is consumed on any cycle where resolve_valid is high and the queue is non-empty.
module gshare_predictor_q
    import bp_pkg::*;
#(
    parameter int INDEX_W = 10,
    parameter int HIST_W  = 10,
    parameter int CTR_W   = 2,
    parameter int PC_W    = 32,
    parameter int QDEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    output logic                     init_busy,
    input  logic                     pred_req,
    input  logic [PC_W-1:0]          pred_pc,
    output logic                     pred_taken,
    output logic                     pred_ready,
    input  logic                     resolve_valid,
    input  logic                     resolve_taken,
    output logic                     resolve_mispredict,
    input  logic                     flush,
    output logic [$clog2(QDEPTH):0]  occupancy,
    output logic                     resolve_err,
    output logic [31:0]              mispredict_cnt
);
    localparam int                 TABLE_DEPTH = 1 << INDEX_W;
    localparam logic [INDEX_W-1:0] LAST_IDX    = INDEX_W'(TABLE_DEPTH - 1);
    localparam logic [CTR_W-1:0]   WEAK_NT     = CTR_W'(weak_nt(CTR_W));

    bp_state_e            state;
    bp_state_e            state_next;
    logic [INDEX_W-1:0]   sweep_idx;
    logic [CTR_W-1:0]     table_mem [TABLE_DEPTH];
    logic [HIST_W-1:0]    spec_hist;
    logic [HIST_W-1:0]    arch_hist;
    logic [HIST_W-1:0]    arch_next;
    logic [HIST_W-1:0]    spec_shift;
    logic [INDEX_W-1:0]   idx;
    logic [INDEX_W-1:0]   head_idx;
    logic                 run;
    logic                 accept;
    logic                 res_fire;
    logic                 clear;
    logic                 wr_en;
    logic [INDEX_W-1:0]   wr_addr;
    logic [CTR_W-1:0]     wr_data;
    bp_entry_t            push_data;
    bp_entry_t            head;
    logic                 q_full;
    logic                 q_empty;

    assign run        = (state == RUN);
    assign init_busy  = ~run;
    assign idx        = pred_pc[INDEX_W-1:0] ^ INDEX_W'(spec_hist);
    assign pred_taken = run & table_mem[idx][CTR_W-1];
    assign pred_ready = run & ~q_full;
    assign accept     = pred_req & pred_ready;
    assign res_fire   = run & resolve_valid & ~q_empty;
    assign head_idx   = head.idx[INDEX_W-1:0];

    assign resolve_mispredict = res_fire & (resolve_taken != head.pred);
    // Mispredict and flush both discard every unresolved entry, including a same-cycle push.
    assign clear      = run & (resolve_mispredict | flush);

    assign arch_next  = res_fire ? ((arch_hist << 1) | HIST_W'(resolve_taken)) : arch_hist;
    assign spec_shift = (spec_hist << 1) | HIST_W'(pred_taken);

    assign push_data  = '{idx: IDX_MAX_W'(idx), pred: pred_taken};

    generate
        if (PC_W > INDEX_W) begin : g_pc_hi
            logic unused_pc_hi;
            assign unused_pc_hi = ^pred_pc[PC_W-1:INDEX_W];
        end
        if (IDX_MAX_W > INDEX_W) begin : g_idx_hi
            logic unused_idx_hi;
            assign unused_idx_hi = ^head.idx[IDX_MAX_W-1:INDEX_W];
        end
    endgenerate

    bp_inflight_q #(
        .DEPTH (QDEPTH)
    ) u_inflight_q (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (clear),
        .push      (accept),
        .push_data (push_data),
        .pop       (res_fire),
        .head      (head),
        .count     (occupancy),
        .full      (q_full),
        .empty     (q_empty)
    );

    // FSM state register and sweep pointer; any reset restarts the sweep at entry 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= INIT;
            sweep_idx <= '0;
        end else begin
            state <= state_next;
            if (state == INIT) sweep_idx <= sweep_idx + 1'b1;
        end
    end

    // Leave INIT on the cycle after the last table entry is written.
    always_comb begin
        state_next = state;
        case (state)
            INIT:    if (sweep_idx == LAST_IDX) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    // Architectural history follows resolves; speculative history follows lookups and is repaired from arch on clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            arch_hist <= '0;
            spec_hist <= '0;
        end else begin
            arch_hist <= arch_next;
            if (clear)       spec_hist <= arch_next;
            else if (accept) spec_hist <= spec_shift;
        end
    end

    // Sticky protocol error and saturating mispredict counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            resolve_err    <= 1'b0;
            mispredict_cnt <= '0;
        end else begin
            if (run && resolve_valid && q_empty) resolve_err <= 1'b1;
            if (resolve_mispredict && (mispredict_cnt != '1)) mispredict_cnt <= mispredict_cnt + 1'b1;
        end
    end

    // Single write port: the sweep owns it during INIT, the resolving head entry during RUN.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = sweep_idx;
        wr_data = WEAK_NT;
        if (state == INIT) begin
            wr_en = 1'b1;
        end else if (res_fire) begin
            wr_en   = 1'b1;
            wr_addr = head_idx;
            wr_data = CTR_W'(sat_step(int'(table_mem[head_idx]), resolve_taken, CTR_W));
        end
    end

    // Counter table; the prediction read sees the pre-write value on a same-cycle collision.
    always_ff @(posedge clk) begin
        if (wr_en) table_mem[wr_addr] <= wr_data;
    end

endmodule

// File: tb/tb_gshare_predictor_q.sv
// Directed bench for gshare_predictor_q with default parameters (10-bit index and history,
// 2-bit counters, 4-deep queue). Inputs change 1ns after a rising edge; outputs are
// checked before the next rising edge.
module tb_gshare_predictor_q;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        pred_req = 1'b0;
    logic [31:0] pred_pc = '0;
    logic        resolve_valid = 1'b0;
    logic        resolve_taken = 1'b0;
    logic        flush = 1'b0;
    logic        init_busy;
    logic        pred_taken;
    logic        pred_ready;
    logic        resolve_mispredict;
    logic [2:0]  occupancy;
    logic        resolve_err;
    logic [31:0] mispredict_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gshare_predictor_q dut (
        .clk                (clk),
        .rstn               (rstn),
        .init_busy          (init_busy),
        .pred_req           (pred_req),
        .pred_pc            (pred_pc),
        .pred_taken         (pred_taken),
        .pred_ready         (pred_ready),
        .resolve_valid      (resolve_valid),
        .resolve_taken      (resolve_taken),
        .resolve_mispredict (resolve_mispredict),
        .flush              (flush),
        .occupancy          (occupancy),
        .resolve_err        (resolve_err),
        .mispredict_cnt     (mispredict_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count cycles until init_busy drops; caller releases rstn 1ns after a rising edge.
    task automatic wait_sweep(output int n);
        n = 0;
        while (init_busy === 1'b1 && n < 4000) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        #2;
        checks++; if (init_busy !== 1'b1) begin failures++; $display("FAIL reset_init_busy got=%0b want=1", init_busy); end
        checks++; if (pred_ready !== 1'b0) begin failures++; $display("FAIL reset_pred_ready got=%0b want=0", pred_ready); end
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL reset_occupancy got=%0d want=0", occupancy); end
        checks++; if (resolve_err !== 1'b0) begin failures++; $display("FAIL reset_resolve_err got=%0b want=0", resolve_err); end
        checks++; if (mispredict_cnt !== 32'd0) begin failures++; $display("FAIL reset_mispredict_cnt got=%0d want=0", mispredict_cnt); end
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL reset_pred_taken got=%0b want=0", pred_taken); end
        tick();
        tick();
        rstn = 1'b1;
        wait_sweep(n);
        checks++; if (n !== 1024) begin failures++; $display("FAIL sweep_cycles got=%0d want=1024", n); end
        checks++; if (pred_ready !== 1'b1) begin failures++; $display("FAIL post_sweep_ready got=%0b want=1", pred_ready); end
    endtask

    task automatic test_init_values();
        logic [31:0] pcs [6];
        pcs = '{32'h0, 32'h1, 32'h40, 32'h155, 32'h3FF, 32'h12345};
        for (int i = 0; i < 6; i++) begin
            pred_pc = pcs[i];
            #1;
            checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL init_pred pc=%0h got=%0b want=0", pcs[i], pred_taken); end
        end
    endtask

    // Train counter 0x40 up to saturation and back down; each pc is chosen so pc ^ history == 0x40.
    task automatic test_train_taken();
        logic [31:0] pcs [6];
        logic        exp_pred [6];
        logic        act [6];
        logic        exp_mis [6];
        pcs      = '{32'h40, 32'h41, 32'h43, 32'h47, 32'h4E, 32'h5C};
        exp_pred = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        act      = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_mis  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            pred_pc  = pcs[i];
            pred_req = 1'b1;
            #1;
            checks++; if (pred_taken !== exp_pred[i]) begin failures++; $display("FAIL train_pred step=%0d got=%0b want=%0b", i, pred_taken, exp_pred[i]); end
            tick();
            pred_req      = 1'b0;
            resolve_valid = 1'b1;
            resolve_taken = act[i];
            #1;
            checks++; if (resolve_mispredict !== exp_mis[i]) begin failures++; $display("FAIL train_mispredict step=%0d got=%0b want=%0b", i, resolve_mispredict, exp_mis[i]); end
            tick();
            resolve_valid = 1'b0;
            checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL train_occupancy step=%0d got=%0d want=0", i, occupancy); end
        end
        checks++; if (mispredict_cnt !== 32'd3) begin failures++; $display("FAIL train_mispredict_cnt got=%0d want=3", mispredict_cnt); end
    endtask

    task automatic test_queue_full();
        pred_pc  = 32'h200;
        pred_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL fill_pred step=%0d got=%0b want=0", i, pred_taken); end
            tick();
            checks++; if (occupancy !== 3'(i + 1)) begin failures++; $display("FAIL fill_occupancy step=%0d got=%0d want=%0d", i, occupancy, i + 1); end
        end
        checks++; if (pred_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%0b want=0", pred_ready); end
        tick();
        checks++; if (occupancy !== 3'd4) begin failures++; $display("FAIL fifth_refused got=%0d want=4", occupancy); end
        resolve_valid = 1'b1;
        resolve_taken = 1'b0;
        #1;
        checks++; if (pred_ready !== 1'b0) begin failures++; $display("FAIL ready_during_resolve got=%0b want=0", pred_ready); end
        checks++; if (resolve_mispredict !== 1'b0) begin failures++; $display("FAIL full_resolve_mis got=%0b want=0", resolve_mispredict); end
        tick();
        resolve_valid = 1'b0;
        checks++; if (occupancy !== 3'd3) begin failures++; $display("FAIL push_refused_on_resolve got=%0d want=3", occupancy); end
        checks++; if (pred_ready !== 1'b1) begin failures++; $display("FAIL ready_after_pop got=%0b want=1", pred_ready); end
        tick();
        pred_req = 1'b0;
        checks++; if (occupancy !== 3'd4) begin failures++; $display("FAIL accepted_next got=%0d want=4", occupancy); end
        for (int i = 0; i < 4; i++) begin
            resolve_valid = 1'b1;
            resolve_taken = 1'b0;
            #1;
            checks++; if (resolve_mispredict !== 1'b0) begin failures++; $display("FAIL drain_mis step=%0d got=%0b want=0", i, resolve_mispredict); end
            tick();
        end
        resolve_valid = 1'b0;
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL drain_occupancy got=%0d want=0", occupancy); end
        checks++; if (mispredict_cnt !== 32'd3) begin failures++; $display("FAIL drain_mispredict_cnt got=%0d want=3", mispredict_cnt); end
    endtask

    // History is 0x300 here; two not-taken lookups then a taken resolve of the head.
    task automatic test_mispredict();
        pred_pc  = 32'h0;
        pred_req = 1'b1;
        tick();
        tick();
        pred_req = 1'b0;
        checks++; if (occupancy !== 3'd2) begin failures++; $display("FAIL mis_occupancy_pre got=%0d want=2", occupancy); end
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        #1;
        checks++; if (resolve_mispredict !== 1'b1) begin failures++; $display("FAIL mis_flag got=%0b want=1", resolve_mispredict); end
        tick();
        resolve_valid = 1'b0;
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL mis_occupancy_post got=%0d want=0", occupancy); end
        checks++; if (mispredict_cnt !== 32'd4) begin failures++; $display("FAIL mis_cnt got=%0d want=4", mispredict_cnt); end
        pred_pc = 32'h101;
        #1;
        checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL mis_hist_repair got=%0b want=1", pred_taken); end
    endtask

    // History 0x201; counter 0x300 is 10. Flush together with a correct resolve and a push.
    task automatic test_flush();
        pred_pc  = 32'h101;
        pred_req = 1'b1;
        #1;
        checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL flush_first_pred got=%0b want=1", pred_taken); end
        tick();
        pred_pc = 32'h0;
        tick();
        checks++; if (occupancy !== 3'd2) begin failures++; $display("FAIL flush_occupancy_pre got=%0d want=2", occupancy); end
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        flush         = 1'b1;
        #1;
        checks++; if (resolve_mispredict !== 1'b0) begin failures++; $display("FAIL flush_resolve_mis got=%0b want=0", resolve_mispredict); end
        tick();
        pred_req      = 1'b0;
        resolve_valid = 1'b0;
        flush         = 1'b0;
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL flush_occupancy got=%0d want=0", occupancy); end
        checks++; if (mispredict_cnt !== 32'd4) begin failures++; $display("FAIL flush_mis_cnt got=%0d want=4", mispredict_cnt); end
        pred_pc = 32'h303;
        #1;
        checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL flush_hist_repair got=%0b want=1", pred_taken); end
        pred_req = 1'b1;
        tick();
        pred_req      = 1'b0;
        resolve_valid = 1'b1;
        resolve_taken = 1'b0;
        #1;
        checks++; if (resolve_mispredict !== 1'b1) begin failures++; $display("FAIL flush_followup_mis got=%0b want=1", resolve_mispredict); end
        tick();
        resolve_valid = 1'b0;
        pred_pc = 32'h306;
        #1;
        checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL flush_table_updated got=%0b want=1", pred_taken); end
        checks++; if (mispredict_cnt !== 32'd5) begin failures++; $display("FAIL flush_followup_cnt got=%0d want=5", mispredict_cnt); end
    endtask

    task automatic test_resolve_err();
        checks++; if (resolve_err !== 1'b0) begin failures++; $display("FAIL err_before got=%0b want=0", resolve_err); end
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        #1;
        checks++; if (resolve_mispredict !== 1'b0) begin failures++; $display("FAIL err_mis_flag got=%0b want=0", resolve_mispredict); end
        tick();
        resolve_valid = 1'b0;
        checks++; if (resolve_err !== 1'b1) begin failures++; $display("FAIL err_set got=%0b want=1", resolve_err); end
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL err_occupancy got=%0d want=0", occupancy); end
        checks++; if (mispredict_cnt !== 32'd5) begin failures++; $display("FAIL err_mis_cnt got=%0d want=5", mispredict_cnt); end
        pred_pc = 32'h306;
        #1;
        checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL err_table_unchanged got=%0b want=1", pred_taken); end
        tick();
        tick();
        tick();
        checks++; if (resolve_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%0b want=1", resolve_err); end
    endtask

    task automatic test_mid_sweep_reset();
        int n;
        rstn = 1'b0;
        #1;
        checks++; if (init_busy !== 1'b1) begin failures++; $display("FAIL rst2_init_busy got=%0b want=1", init_busy); end
        checks++; if (resolve_err !== 1'b0) begin failures++; $display("FAIL rst2_resolve_err got=%0b want=0", resolve_err); end
        checks++; if (mispredict_cnt !== 32'd0) begin failures++; $display("FAIL rst2_mis_cnt got=%0d want=0", mispredict_cnt); end
        tick();
        rstn          = 1'b1;
        pred_req      = 1'b1;
        resolve_valid = 1'b1;
        pred_pc       = 32'h300;
        repeat (500) tick();
        checks++; if (init_busy !== 1'b1) begin failures++; $display("FAIL mid_sweep_busy got=%0b want=1", init_busy); end
        rstn = 1'b0;
        #1;
        tick();
        rstn = 1'b1;
        wait_sweep(n);
        pred_req      = 1'b0;
        resolve_valid = 1'b0;
        checks++; if (n !== 1024) begin failures++; $display("FAIL restart_sweep_cycles got=%0d want=1024", n); end
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL init_ignores_req got=%0d want=0", occupancy); end
        checks++; if (resolve_err !== 1'b0) begin failures++; $display("FAIL init_ignores_resolve got=%0b want=0", resolve_err); end
        #1;
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL resweep_pc300 got=%0b want=0", pred_taken); end
        pred_pc = 32'h40;
        #1;
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL resweep_pc40 got=%0b want=0", pred_taken); end
    endtask

    initial begin
        test_reset();
        test_init_values();
        test_train_taken();
        test_queue_full();
        test_mispredict();
        test_flush();
        test_resolve_err();
        test_mid_sweep_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gshare_predictor_q.md
Name: gshare_predictor_q

Overview:
Parametrised gshare direction predictor for the fetch/decode stage.
- Predicts conditional branches from a table of saturating counters, indexed by speculative global history XOR PC.
- Keeps in-flight predictions in an in-order queue, so resolution updates the exact counter that produced the prediction. No PC matching.
- Repairs speculative history on mispredict or pipeline flush.
- After reset, sweeps the table to weakly-not-taken.

Parameters:
INDEX_W, 10, table index width; table depth 2^INDEX_W
HIST_W, 10, global history length; legal range 1..INDEX_W; XORed into index bits [HIST_W-1:0]
CTR_W, 2, counter width; legal range 2..4
PC_W, 32, PC width; PC is word-addressed, index uses pc[INDEX_W-1:0]
QDEPTH, 4, maximum unresolved branches; power of two, minimum 2

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
init_busy  out  1  table sweep in progress
pred_req  in  1  conditional branch lookup this cycle
pred_pc  in  PC_W  PC of the branch
pred_taken  out  1  prediction, combinational from pred_pc and current history
pred_ready  out  1  lookup accepted (not init, queue not full)
resolve_valid  in  1  oldest unresolved branch resolved, in program order
resolve_taken  in  1  actual direction
resolve_mispredict  out  1  combinational: resolve_valid & queue non-empty & resolve_taken != head prediction
flush  in  1  discard all unresolved entries (non-branch redirect)
occupancy  out  $clog2(QDEPTH)+1  queue entries in use
resolve_err  out  1  sticky: resolve_valid arrived with queue empty
mispredict_cnt  out  32  saturating count of mispredicts

Behaviour:
- Reset (async):
  - spec_hist=0, arch_hist=0, queue empty, occupancy=0.
  - resolve_err=0, mispredict_cnt=0, state=INIT, sweep index=0.
  - init_busy=1, pred_ready=0.
  - Table contents are not reset; the sweep initialises them.
- State INIT:
  - Writes WEAK_NT = 2^(CTR_W-1)-1 to one entry per cycle, ascending.
  - Enters RUN the cycle after writing the last entry, so init_busy is high for exactly 2^INDEX_W cycles.
  - pred_req, resolve_valid and flush are ignored.
  - rstn asserted mid-sweep restarts the sweep at 0.
- State RUN:
  - Index: idx = pred_pc[INDEX_W-1:0] ^ zero-extend(spec_hist).
  - Prediction: pred_taken = counter[idx] MSB. Same-cycle read; on a read/write collision the read returns the pre-write value.
  - pred_ready = (occupancy < QDEPTH). It does not depend on the resolve inputs, so there is no combinational path from resolve to ready.
  - Accept (pred_req & pred_ready):
    - Push {idx, pred_taken}.
    - spec_hist <= {spec_hist[HIST_W-2:0], pred_taken}.
  - Resolve (resolve_valid & occupancy>0):
    - Pop head; arch_hist <= {arch_hist[HIST_W-2:0], resolve_taken}.
    - Counter at head idx: +1 if taken, -1 if not, saturating at 0 and 2^CTR_W-1.
  - Resolve with occupancy==0:
    - Set resolve_err; no table, history or queue change.
  - Mispredict:
    - Queue cleared, including any push in the same cycle.
    - spec_hist <= updated arch_hist (shifted with resolve_taken).
    - mispredict_cnt += 1, saturating at 2^32-1.
  - flush:
    - Queue cleared; spec_hist <= arch_hist value after any same-cycle resolve.
    - A same-cycle push is discarded.
    - A same-cycle resolve is applied first: the table update still occurs.
  - Push and correct resolve in the same cycle: both occur; occupancy unchanged.
  - Single table write port (resolve only); single read port (prediction).

Decomposition:
- Package bp_pkg holds:
  - WEAK_NT function of CTR_W;
  - typedef bp_entry_t {idx[INDEX_W-1:0], pred};
  - state enum {INIT, RUN};
  - saturating increment/decrement function.
- Sub-module bp_inflight_q: parametrised circular queue of bp_entry_t.
  - Pointers wrap modulo QDEPTH; count is kept separately so full/empty are unambiguous.
  - Synchronous clear input.

Test Plan:
- Reset, release rstn -> init_busy high exactly 1024 cycles; table reads 01 everywhere; pred_taken=0 for all PCs.
- Branch at pc=0x40 resolved taken 3 times, each resolved before the next lookup -> counter[0x40^hist] goes 01→10→11→11 (saturates); pred_taken=1 once counter ≥10; history bits shift in 1s.
- Four lookups with no resolve -> occupancy=4, pred_ready=0; a fifth pred_req is not accepted; one resolve same cycle as pred_req -> push still refused, accepted next cycle.
- Two in-flight predictions not-taken, resolve head taken -> resolve_mispredict=1; occupancy=0 next cycle; spec_hist=arch_hist ending in 1; mispredict_cnt=1.
- flush with a simultaneous correct resolve and pred_req -> head counter updated; push dropped; occupancy=0; spec_hist=new arch_hist.
- resolve_valid with empty queue -> resolve_err=1 and stays set; table unchanged. Also assert rstn at sweep index 500 -> sweep restarts at 0, full 1024 cycles.
